// File: rtl/alu_div_8bit_pkg.sv
// Shared ALU definitions: default datapath width and the divider state encoding.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_div_8bit_if.sv
// Start/busy/done handshake bundle between ALU control (master) and the divider (slave).
interface alu_div_8bit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/alu_div_8bit_sub.sv
// Ripple-chain subtractor a + ~b + 1; borrow is the inverted carry-out.
module alu_sub_nbit #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0] carry;

  // Carry ripples LSB to MSB, seeded with 1 for the two's-complement of b.
  always_comb begin
    carry    = '0;
    diff     = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i]      = a[i] ^ ~b[i] ^ carry[i];
      carry[i + 1] = (a[i] & ~b[i]) | (carry[i] & (a[i] ^ ~b[i]));
    end
    borrow = ~carry[WIDTH];
  end

endmodule

// File: rtl/alu_div_8bit.sv
// Iterative restoring divider: one quotient bit per clock, start/busy/done handshake.
module alu_div_8bit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  alu_div_8bit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_t       state;
  div_state_t       next_state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor_q;
  logic             dbz;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   rem_shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;

  assign shifted     = {rem, q} << 1;
  assign rem_shifted = shifted[2*WIDTH:WIDTH];

  alu_sub_nbit #(.WIDTH(WIDTH + 1)) u_sub (
    .a      (rem_shifted),
    .b      ({1'b0, divisor_q}),
    .diff   (trial),
    .borrow (borrow)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a zero divisor skips the iterations entirely.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          next_state = (bus.divisor == '0) ? S_DONE : S_CALC;
        end else begin
          next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt == CW'(1)) begin
          next_state = S_DONE;
        end else begin
          next_state = S_CALC;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand capture and the shift/trial-subtract iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      rem       <= '0;
      q         <= '0;
      divisor_q <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            divisor_q <= bus.divisor;
            cnt       <= CW'(WIDTH);
            if (bus.divisor == '0) begin
              q   <= '1;
              rem <= {1'b0, bus.dividend};
              dbz <= 1'b1;
            end else begin
              q   <= bus.dividend;
              rem <= '0;
              dbz <= 1'b0;
            end
          end
        end
        S_CALC: begin
          rem <= borrow ? rem_shifted : trial;
          q   <= {shifted[WIDTH-1:1], ~borrow};
          cnt <= cnt - CW'(1);
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // Registered outputs; results are published from DONE and then held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy <= (state != S_IDLE);
      bus.done <= (state == S_DONE);
      if (state == S_DONE) begin
        bus.quotient    <= q;
        bus.remainder   <= rem[WIDTH-1:0];
        bus.div_by_zero <= dbz;
      end else if (state == S_IDLE && bus.start) begin
        bus.div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_div_8bit.sv
// Directed and swept checks of the restoring divider against hand values and a reference model.
module tb_alu_div_8bit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  alu_div_8bit_if #(.WIDTH(8)) bus ();

  alu_div_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end else begin
      passes++;
    end
  endtask

  // Issue one division from #1 after a rising edge; return once done is seen (or budget expires).
  task automatic run_div(input logic [7:0] a, input logic [7:0] b, input logic hold,
                         input logic [7:0] alt_a, input logic [7:0] alt_b,
                         output int lat, output int busy_cnt);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    lat      = 0;
    busy_cnt = 0;
    if (hold) begin
      bus.dividend = alt_a;
      bus.divisor  = alt_b;
    end else begin
      bus.start = 1'b0;
    end
    if (bus.busy) busy_cnt++;
    while (!bus.done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.busy) busy_cnt++;
    end
    bus.start = 1'b0;
    if (!bus.done) check_val("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    int eq, er, ez;
    if (b == 0) begin
      eq = 255; er = a; ez = 1;
    end else begin
      eq = a / b; er = a % b; ez = 0;
    end
    check_val({tag, "_q"}, int'(bus.quotient), eq);
    check_val({tag, "_r"}, int'(bus.remainder), er);
    check_val({tag, "_z"}, int'(bus.div_by_zero), ez);
  endtask

  initial begin
    int lat, bc;
    logic [7:0] ra, rb;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 8'd0;
    #12;
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_done", int'(bus.done), 0);
    check_val("rst_q", int'(bus.quotient), 0);
    check_val("rst_r", int'(bus.remainder), 0);
    check_val("rst_z", int'(bus.div_by_zero), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_div(8'd100, 8'd7, 1'b0, 8'd0, 8'd0, lat, bc);
    check_val("lat_100_7", lat, 9);
    check_val("busy_cycles", bc, 9);
    check_val("q_100_7", int'(bus.quotient), 14);
    check_val("r_100_7", int'(bus.remainder), 2);
    check_val("z_100_7", int'(bus.div_by_zero), 0);
    @(posedge clk);
    #1;
    check_val("done_pulse", int'(bus.done), 0);
    check_val("busy_after", int'(bus.busy), 0);

    run_div(8'd255, 8'd1, 1'b0, 8'd0, 8'd0, lat, bc);
    check_val("q_255_1", int'(bus.quotient), 255);
    check_val("r_255_1", int'(bus.remainder), 0);
    run_div(8'd5, 8'd9, 1'b0, 8'd0, 8'd0, lat, bc);
    check_val("q_5_9", int'(bus.quotient), 0);
    check_val("r_5_9", int'(bus.remainder), 5);
    run_div(8'd255, 8'd255, 1'b0, 8'd0, 8'd0, lat, bc);
    check_val("q_255_255", int'(bus.quotient), 1);
    check_val("r_255_255", int'(bus.remainder), 0);

    run_div(8'd200, 8'd0, 1'b0, 8'd0, 8'd0, lat, bc);
    check_val("lat_dbz", lat, 1);
    check_val("q_dbz", int'(bus.quotient), 255);
    check_val("r_dbz", int'(bus.remainder), 200);
    check_val("z_dbz", int'(bus.div_by_zero), 1);

    // start held high with other operands through CALC and DONE must be ignored.
    run_div(8'd100, 8'd7, 1'b1, 8'd50, 8'd3, lat, bc);
    check_val("lat_hold", lat, 9);
    check_val("q_hold", int'(bus.quotient), 14);
    check_val("r_hold", int'(bus.remainder), 2);
    check_val("z_cleared", int'(bus.div_by_zero), 0);
    bus.dividend = 8'd9;
    bus.divisor  = 8'd4;
    repeat (5) @(posedge clk);
    #1;
    check_val("held_q", int'(bus.quotient), 14);
    check_val("held_r", int'(bus.remainder), 2);
    check_val("held_busy", int'(bus.busy), 0);

    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_val("arst_busy", int'(bus.busy), 0);
    check_val("arst_done", int'(bus.done), 0);
    check_val("arst_q", int'(bus.quotient), 0);
    check_val("arst_r", int'(bus.remainder), 0);
    check_val("arst_z", int'(bus.div_by_zero), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("post_rst_busy", int'(bus.busy), 0);
    run_div(8'd50, 8'd6, 1'b0, 8'd0, 8'd0, lat, bc);
    check_val("lat_50_6", lat, 9);
    check_val("q_50_6", int'(bus.quotient), 8);
    check_val("r_50_6", int'(bus.remainder), 2);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_div(ra, rb, 1'b0, 8'd0, 8'd0, lat, bc);
      check_result("rand", int'(ra), int'(rb));
    end
    for (int d = 0; d < 256; d++) begin
      run_div(8'd171, 8'(d), 1'b0, 8'd0, 8'd0, lat, bc);
      check_result("sweep171", 171, d);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
